// File: rtl/rtc_div_pkg.sv
// rtl/rtc_div_pkg.sv - shared types and helpers for the multi-channel RTC divider
package rtc_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_STROBE = 1'b1
  } rtc_mode_e;

  localparam int MIN_DIV = 2;

  function automatic logic div_valid(input logic [31:0] d);
    return d >= 32'(MIN_DIV);
  endfunction

  // First count value at which the square output is high; low phase gets the odd cycle.
  function automatic logic [31:0] hi_threshold(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/rtc_clk_divider_multi_if.sv
// rtl/rtc_clk_divider_multi_if.sv - valid/ready configuration port of the divider
interface rtc_clk_divider_multi_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 24
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_mode, output cfg_ready);
endinterface

// File: rtl/rtc_div_channel.sv
// rtl/rtc_div_channel.sv - one divider channel: counter, active/shadow config, outputs
module rtc_div_channel
  import rtc_div_pkg::*;
#(
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] DIV_RST  = CNT_W'(2000),
  parameter logic             MODE_RST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             acc_i,
  input  logic [CNT_W-1:0] acc_div_i,
  input  rtc_mode_e        acc_mode_i,
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, div_q, sh_div_q, thr;
  rtc_mode_e        mode_q, sh_mode_q;
  logic             pend_q, clk_out_q, tick_q, wrap;

  assign wrap = en_i && (cnt_q == div_q - CNT_W'(1));
  assign thr  = CNT_W'(hi_threshold(32'(div_q)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      mode_q    <= rtc_mode_e'(MODE_RST);
      sh_div_q  <= DIV_RST;
      sh_mode_q <= rtc_mode_e'(MODE_RST);
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else if (restart_i) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      if (acc_i) begin
        div_q     <= acc_div_i;
        mode_q    <= acc_mode_i;
        sh_div_q  <= acc_div_i;
        sh_mode_q <= acc_mode_i;
      end else if (pend_q) begin
        div_q  <= sh_div_q;
        mode_q <= sh_mode_q;
      end
    end else begin
      if (!en_i) begin
        cnt_q     <= '0;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= wrap ? '0 : cnt_q + CNT_W'(1);
        tick_q    <= wrap;
        clk_out_q <= (mode_q == MODE_STROBE) ? wrap : (cnt_q >= thr);
      end
      // Swap config only at a period boundary so no runt pulse is emitted.
      if (pend_q && (wrap || !en_i)) begin
        div_q  <= sh_div_q;
        mode_q <= sh_mode_q;
        pend_q <= 1'b0;
      end
      if (acc_i) begin
        sh_div_q  <= acc_div_i;
        sh_mode_q <= acc_mode_i;
        pend_q    <= 1'b1;
      end
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/rtc_clk_divider_multi.sv
// rtl/rtc_clk_divider_multi.sv - N-channel programmable RTC clock divider
module rtc_clk_divider_multi
  import rtc_div_pkg::*;
#(
  parameter int                      N_CH     = 2,
  parameter int                      CNT_W    = 24,
  parameter logic [N_CH*CNT_W-1:0]   DIV_RST  = {24'd5_000_000, 24'd2_000},
  parameter logic [N_CH-1:0]         MODE_RST = 2'b00
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync_restart,
  rtc_clk_divider_multi_if.slave cfg,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic                  div_err
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]      pend, acc;
  logic [2**CH_W-1:0]   pend_ext;
  logic                 hs, cfg_ok, div_err_q;

  // Out-of-range channels read as not pending so they are accepted and then rejected.
  always_comb begin
    pend_ext            = '0;
    pend_ext[N_CH-1:0]  = pend;
  end

  assign cfg.cfg_ready = !pend_ext[cfg.cfg_ch];
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok        = div_valid(32'(cfg.cfg_div)) &&
                         ({1'b0, cfg.cfg_ch} < (CH_W+1)'(N_CH));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div_err_q <= 1'b0;
    else            div_err_q <= hs && !cfg_ok;
  end

  assign div_err = div_err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign acc[i] = hs && cfg_ok && (cfg.cfg_ch == CH_W'(i));

    rtc_div_channel #(
      .CNT_W    (CNT_W),
      .DIV_RST  (DIV_RST[i*CNT_W +: CNT_W]),
      .MODE_RST (MODE_RST[i])
    ) u_ch (
      .clk_i      (sys_clk),
      .rst_ni     (sys_rst_n),
      .en_i       (en[i]),
      .restart_i  (sync_restart),
      .acc_i      (acc[i]),
      .acc_div_i  (cfg.cfg_div),
      .acc_mode_i (rtc_mode_e'(cfg.cfg_mode)),
      .pend_o     (pend[i]),
      .clk_out_o  (clk_out[i]),
      .tick_o     (tick[i])
    );
  end

endmodule

// File: tb/tb_rtc_clk_divider_multi.sv
// tb/tb_rtc_clk_divider_multi.sv - self-checking bench for rtc_clk_divider_multi
module tb_rtc_clk_divider_multi;

  localparam int LIM = 200;

  typedef struct {
    int   ch;
    int   div;
    logic mode;
    int   exp_hi;
    int   exp_lo;
    int   exp_tp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic       sync_restart;
  logic [2:0] clk_out, tick;
  logic       div_err;

  int n_chk = 0;
  int n_fail = 0;
  int rises, t0, t1, hi0, hi1, run, n, co, first1, hi, lo, tp;
  logic p;
  vec_t vecs[6];

  rtc_clk_divider_multi_if #(.N_CH(3), .CNT_W(24)) cfg_if ();

  rtc_clk_divider_multi #(
    .N_CH     (3),
    .CNT_W    (24),
    .DIV_RST  ({24'd7, 24'd5_000_000, 24'd2_000}),
    .MODE_RST (3'b000)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg          (cfg_if),
    .clk_out      (clk_out),
    .tick         (tick),
    .div_err      (div_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input int ch, input int div, input logic mode, input logic rs);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 24'(div);
    cfg_if.cfg_mode  = mode;
    sync_restart     = rs;
    step();
    cfg_if.cfg_valid = 1'b0;
    sync_restart     = 1'b0;
  endtask

  task automatic measure(input int ch, output int mhi, output int mlo, output int mtp);
    int k;
    logic q;
    k = 0;
    q = clk_out[ch];
    step();
    while (!(clk_out[ch] && !q) && k < LIM) begin q = clk_out[ch]; step(); k++; end
    mhi = 0;
    while (clk_out[ch] && mhi < LIM) begin mhi++; step(); end
    mlo = 0;
    while (!clk_out[ch] && mlo < LIM) begin mlo++; step(); end
    k = 0;
    while (!tick[ch] && k < LIM) begin step(); k++; end
    step();
    mtp = 1;
    while (!tick[ch] && mtp < LIM) begin step(); mtp++; end
  endtask

  initial begin
    vecs[0] = '{0, 3, 1'b1, 1, 2, 3};
    vecs[1] = '{1, 5, 1'b0, 2, 3, 5};
    vecs[2] = '{0, 2, 1'b0, 1, 1, 2};
    vecs[3] = '{1, 2, 1'b1, 1, 1, 2};
    vecs[4] = '{0, 7, 1'b0, 3, 4, 7};
    vecs[5] = '{2, 6, 1'b0, 3, 3, 6};

    rst_n = 1'b0; en = 3'b000; sync_restart = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = '0; cfg_if.cfg_mode = 1'b0;
    step(); step();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_div_err", 32'(div_err), 0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    rst_n = 1'b1;
    step(); step();

    // Default divisors over 10000 cycles
    en = 3'b011;
    rises = 0; t0 = 0; t1 = 0; hi0 = 0; hi1 = 0; p = 1'b0;
    for (int j = 0; j < 10000; j++) begin
      step();
      if (clk_out[0] && !p) rises++;
      p = clk_out[0];
      t0 += 32'(tick[0]); t1 += 32'(tick[1]);
      hi0 += 32'(clk_out[0]); hi1 += 32'(clk_out[1]);
    end
    chk("def_ch0_rises", rises, 5);
    chk("def_ch0_ticks", t0, 5);
    chk("def_ch0_high_cycles", hi0, 5000);
    chk("def_ch1_ticks", t1, 0);
    chk("def_ch1_high_cycles", hi1, 0);

    // Reconfigure ch0 mid-period at cnt=700
    repeat (700) step();
    cfg_if.cfg_ch = 2'd0;
    chk("reconf_ready_before", 32'(cfg_if.cfg_ready), 1);
    drive_cfg(0, 10, 1'b0, 1'b0);
    n = 0; run = 0;
    while (!cfg_if.cfg_ready && n < 3000) begin
      n++;
      if (clk_out[0]) run++; else run = 0;
      step();
    end
    if (clk_out[0]) run++;
    chk("reconf_ready_low_cycles", n, 1299);
    chk("reconf_last_old_high", run, 1000);
    measure(0, hi, lo, tp);
    chk("reconf_hi", hi, 5);
    chk("reconf_lo", lo, 5);
    chk("reconf_tp", tp, 10);

    // Table: configure with restart (immediate apply), then measure
    en = 3'b111;
    for (int i = 0; i < 6; i++) begin
      drive_cfg(vecs[i].ch, vecs[i].div, vecs[i].mode, 1'b1);
      chk($sformatf("vec%0d_div_err", i), 32'(div_err), 0);
      measure(vecs[i].ch, hi, lo, tp);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("vec%0d_tp", i), tp, vecs[i].exp_tp);
    end

    // Rejected configs
    cfg_if.cfg_ch = 2'd0;
    drive_cfg(0, 1, 1'b0, 1'b0);
    chk("rej_div1_err", 32'(div_err), 1);
    chk("rej_div1_ready", 32'(cfg_if.cfg_ready), 1);
    step();
    chk("rej_div1_err_end", 32'(div_err), 0);
    drive_cfg(3, 10, 1'b0, 1'b0);
    chk("rej_ch3_err", 32'(div_err), 1);
    step();
    chk("rej_ch3_err_end", 32'(div_err), 0);
    cfg_if.cfg_ch = 2'd0;
    chk("rej_ch0_ready", 32'(cfg_if.cfg_ready), 1);
    measure(0, hi, lo, tp);
    chk("rej_ch0_hi", hi, 3);
    chk("rej_ch0_lo", lo, 4);
    chk("rej_ch0_tp", tp, 7);

    // sync_restart with a pending ch1 config (accepted on a ch1 wrap)
    drive_cfg(0, 4, 1'b0, 1'b1);
    drive_cfg(1, 6, 1'b0, 1'b1);
    repeat (5) step();
    drive_cfg(1, 10, 1'b0, 1'b0);
    chk("sync_accept_on_wrap_tick", 32'(tick[1]), 1);
    chk("sync_pending_ready", 32'(cfg_if.cfg_ready), 0);
    step(); step();
    chk("sync_still_pending", 32'(cfg_if.cfg_ready), 0);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("sync_clk_out", 32'(clk_out), 0);
    chk("sync_tick", 32'(tick), 0);
    chk("sync_ready_after", 32'(cfg_if.cfg_ready), 1);
    co = 0; t0 = 0; first1 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick[1] && first1 == 0) first1 = k;
      if (tick[0] && tick[1]) co++;
      t0 += 32'(tick[0]);
    end
    chk("sync_ch1_first_tick", first1, 10);
    chk("sync_coincident_ticks", co, 2);
    chk("sync_ch0_ticks", t0, 10);

    // Drop en[0] mid-high, then async reset with a pending config
    drive_cfg(1, 1000, 1'b0, 1'b1);
    drive_cfg(0, 10, 1'b0, 1'b1);
    n = 0;
    while (!clk_out[0] && n < 50) begin step(); n++; end
    chk("en_drop_pre_high", 32'(clk_out[0]), 1);
    en = 3'b010;
    step();
    chk("en_drop_clk_out", 32'(clk_out[0]), 0);
    chk("en_drop_tick", 32'(tick[0]), 0);
    en = 3'b011;
    cfg_if.cfg_ch = 2'd1;
    chk("rst_pend_ready_before", 32'(cfg_if.cfg_ready), 1);
    drive_cfg(1, 20, 1'b0, 1'b0);
    chk("rst_pend_set", 32'(cfg_if.cfg_ready), 0);
    n = 0;
    while (!clk_out[0] && n < 50) begin step(); n++; end
    chk("rst_pre_high", 32'(clk_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", 32'(clk_out), 0);
    chk("async_rst_tick", 32'(tick), 0);
    chk("async_rst_pend_lost", 32'(cfg_if.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; t1 = 0;
    while (n < 2500) begin
      step();
      n++;
      t1 += 32'(tick[1]);
      if (tick[0]) break;
    end
    chk("post_rst_ch0_first_tick", n, 2000);
    chk("post_rst_ch1_ticks", t1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
